// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoder
// for the sequential Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Overlapping 3-bit multiplier group to a signed digit
  function automatic digit_t recode(input logic [2:0] g);
    digit_t d;
    d = ZERO;
    unique case (g)
      3'b000, 3'b111: d = ZERO;
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Partial product select: digit times multiplicand,
// weighted by 4^idx; negatives as ~x with carry-in.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  digit_t               digit,
  input  logic [WIDTH+1:0]     a_ext,
  input  logic [CW-1:0]        idx,
  output logic [2*WIDTH+3:0]   pp,
  output logic                 cin
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * WIDTH + 4;

  logic [AW-1:0] a_sx;
  logic [AW-1:0] mag;
  logic [AW-1:0] sh;
  logic          neg;

  assign a_sx = {{(AW-EW){a_ext[EW-1]}}, a_ext};

  // Pick magnitude and sign for the current digit
  always_comb begin
    mag = '0;
    neg = 1'b0;
    unique case (digit)
      ZERO: mag = '0;
      POS1: mag = a_sx;
      POS2: mag = a_sx << 1;
      NEG1: begin
        mag = a_sx;
        neg = 1'b1;
      end
      NEG2: begin
        mag = a_sx << 1;
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
  end

  assign sh  = mag << {idx, 1'b0};
  assign pp  = neg ? ~sh : sh;
  assign cin = neg;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit
// per cycle, signed or unsigned per request.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [EW-1:0] a_ext;
  logic [EW:0]   mreg;
  digit_t        digit;
  logic [AW-1:0] pp;
  logic          cin;
  logic          unused_hi;

  assign digit = recode(mreg[2:0]);

  booth_pp_sel #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_pp_sel (
    .digit (digit),
    .a_ext (a_ext),
    .idx   (cnt),
    .pp    (pp),
    .cin   (cin)
  );

  // FSM, operand capture and accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_ext <= '0;
      mreg  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_ext <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a}
                               : {2'b00, in_a};
            mreg  <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0}
                               : {2'b00, in_b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc  <= acc + pp + {{(AW-1){1'b0}}, cin};
          mreg <= mreg >> 2;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_BUSY);
  assign out_valid = (state == ST_DONE);
  assign out_prod  = out_valid ? acc[2*WIDTH-1:0] : '0;
  assign unused_hi = ^acc[AW-1:2*WIDTH];

endmodule
